// File: rtl/spi_frame_receiver.sv
// SPI mode-0 target, MSB first. Oversamples SCLK/CS/MOSI on the system clock,
// assembles words from MOSI, returns tx_data words on MISO and reports
// per-word and per-frame status.
module spi_frame_receiver #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              CLK_16MHZ,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic [WORD_W-1:0] tx_data,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_active,
  output logic              frame_error,
  output logic [CNT_W-1:0]  byte_count
);

  localparam int BCW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Byte counter increments but sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // Sync chains: [0]/[1] are the two synchroniser stages, [2] is edge history.
  logic [2:0]        sclk_q, sclk_d;
  logic [2:0]        cs_q, cs_d;
  logic [1:0]        mosi_q, mosi_d;
  // Marks when the CS chain holds pin values rather than its reset fill.
  logic [1:0]        fill_q, fill_d;
  logic              armed_q, armed_d;
  state_t            state_q, state_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] rx_shift_q, rx_shift_d;
  logic [WORD_W-1:0] tx_shift_q, tx_shift_d;
  logic              skip_q, skip_d;
  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_error_q, frame_error_d;
  logic [CNT_W-1:0]  byte_count_q, byte_count_d;

  logic              sclk_rise, sclk_fall, cs_rise, cs_fall, cs_s, mosi_s;
  logic [WORD_W-1:0] word_next;

  assign cs_s      = cs_q[1];
  assign mosi_s    = mosi_q[1];
  assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] &  sclk_q[2];
  assign cs_rise   =  cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] &  cs_q[2];
  assign word_next = {rx_shift_q[WORD_W-2:0], mosi_s};

  assign spi_miso     = (state_q == ACTIVE) ? tx_shift_q[WORD_W-1] : 1'b0;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign frame_active = (state_q == ACTIVE);
  assign frame_error  = frame_error_q;
  assign byte_count   = byte_count_q;

  // Next-state logic for synchronisers, FSM and datapath.
  always_comb begin
    sclk_d        = {sclk_q[1:0], spi_sclk};
    cs_d          = {cs_q[1:0], spi_cs_n};
    mosi_d        = {mosi_q[0], spi_mosi};
    fill_d        = {fill_q[0], 1'b1};
    // Arming only counts CS high once the chain carries real pin samples, so
    // a CS already low at reset release cannot look like a fresh falling edge.
    armed_d       = armed_q | (fill_q[1] & cs_s);
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    skip_d        = skip_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_error_d = 1'b0;
    byte_count_d  = byte_count_q;
    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_d      = ACTIVE;
          bit_cnt_d    = '0;
          byte_count_d = '0;
          tx_shift_d   = tx_data;
          skip_d       = 1'b0;
        end
      end
      ACTIVE: begin
        // CS release has priority over any SCLK edge in the same cycle.
        if (cs_rise) begin
          state_d       = IDLE;
          frame_error_d = (bit_cnt_q != '0);
          bit_cnt_d     = '0;
        end else if (sclk_rise) begin
          rx_shift_d = word_next;
          if (bit_cnt_q == BCW'(WORD_W - 1)) begin
            rx_data_d    = word_next;
            rx_valid_d   = 1'b1;
            bit_cnt_d    = '0;
            byte_count_d = sat_inc(byte_count_q);
            tx_shift_d   = tx_data;
            skip_d       = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          // The reloaded MSB is already on MISO; keep it for the next rise.
          if (skip_q) skip_d = 1'b0;
          else        tx_shift_d = {tx_shift_q[WORD_W-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK_16MHZ) begin
    if (rst) begin
      sclk_q        <= 3'b000;
      cs_q          <= 3'b111;
      mosi_q        <= 2'b00;
      fill_q        <= 2'b00;
      armed_q       <= 1'b0;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      skip_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      byte_count_q  <= '0;
    end else begin
      sclk_q        <= sclk_d;
      cs_q          <= cs_d;
      mosi_q        <= mosi_d;
      fill_q        <= fill_d;
      armed_q       <= armed_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      skip_q        <= skip_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
      byte_count_q  <= byte_count_d;
    end
  end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench for spi_frame_receiver: the bench acts as SPI master at
// 1 MHz (8 system clocks per SCLK phase) and checks words, pulses and MISO.
module tb_spi_frame_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_active;
  logic       frame_error;
  logic [7:0] byte_count;

  spi_frame_receiver #(.WORD_W(8), .CNT_W(8)) dut (
    .CLK_16MHZ   (clk),
    .rst         (rst),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .tx_data     (tx_data),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_active(frame_active),
    .frame_error (frame_error),
    .byte_count  (byte_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse monitors, sampled away from the active edge.
  int         rxv_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         fa_low_cnt = 0;
  logic       in_frame = 1'b0;
  logic [7:0] rx_log [$];

  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt <= rxv_cnt + 1;
      rx_log.push_back(rx_data);
    end
    if (frame_error) ferr_cnt <= ferr_cnt + 1;
    if (rx_valid && frame_error) both_cnt <= both_cnt + 1;
    if (in_frame && !frame_active) fa_low_cnt <= fa_low_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master shifts nbits of mosi_b MSB first; samples MISO before each rise.
  task automatic spi_bits(input logic [7:0] mosi_b, input int nbits, output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mosi_b[7-i];
      clks(8);
      miso_b[7-i] = spi_miso;
      spi_sclk = 1'b1;
      clks(8);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    clks(8);
  endtask

  task automatic cs_high();
    clks(8);
    spi_cs_n = 1'b1;
    clks(8);
  endtask

  int         rxv0, ferr0, log0, fa0;
  logic [7:0] mb;

  initial begin
    // Reset state
    clks(3);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_frame_active", frame_active, 1'b0);
    chk("rst_frame_error", frame_error, 1'b0);
    chk("rst_byte_count", byte_count, 8'h00);
    chk("rst_miso", spi_miso, 1'b0);
    rst = 1'b0;
    clks(6);

    // 1: single 0xA5 frame
    rxv0 = rxv_cnt; ferr0 = ferr_cnt;
    cs_low();
    spi_bits(8'hA5, 8, mb);
    chk("t1_active", frame_active, 1'b1);
    cs_high();
    chk("t1_rx_data", rx_data, 8'hA5);
    chk("t1_rxv_count", rxv_cnt - rxv0, 1);
    chk("t1_byte_count", byte_count, 8'd1);
    chk("t1_no_error", ferr_cnt - ferr0, 0);
    chk("t1_inactive", frame_active, 1'b0);

    // 2: three back-to-back words in one frame
    rxv0 = rxv_cnt; log0 = rx_log.size(); fa0 = fa_low_cnt;
    cs_low();
    in_frame = 1'b1;
    spi_bits(8'h01, 8, mb);
    spi_bits(8'h02, 8, mb);
    spi_bits(8'hFF, 8, mb);
    in_frame = 1'b0;
    cs_high();
    chk("t2_rxv_count", rxv_cnt - rxv0, 3);
    chk("t2_log_size", rx_log.size() - log0, 3);
    if (rx_log.size() - log0 == 3) begin
      chk("t2_word0", rx_log[log0], 8'h01);
      chk("t2_word1", rx_log[log0+1], 8'h02);
      chk("t2_word2", rx_log[log0+2], 8'hFF);
    end
    chk("t2_byte_count", byte_count, 8'd3);
    chk("t2_active_throughout", fa_low_cnt - fa0, 0);

    // 3: MISO returns tx_data, reloaded per word
    tx_data = 8'h3C;
    cs_low();
    tx_data = 8'hC3;
    spi_bits(8'h00, 8, mb);
    chk("t3_miso_word0", mb, 8'h3C);
    spi_bits(8'h11, 8, mb);
    chk("t3_miso_word1", mb, 8'hC3);
    cs_high();
    chk("t3_byte_count", byte_count, 8'd2);
    chk("t3_rx_data", rx_data, 8'h11);
    chk("t3_idle_miso", spi_miso, 1'b0);

    // 4: CS released after 5 bits
    rxv0 = rxv_cnt; ferr0 = ferr_cnt;
    cs_low();
    spi_bits(8'hF0, 5, mb);
    cs_high();
    chk("t4_error_count", ferr_cnt - ferr0, 1);
    chk("t4_no_rxv", rxv_cnt - rxv0, 0);
    chk("t4_rx_data_kept", rx_data, 8'h11);
    chk("t4_inactive", frame_active, 1'b0);
    chk("t4_byte_count", byte_count, 8'd0);

    // 5: reset mid-byte with CS held low, then a clean 0x5A frame
    rxv0 = rxv_cnt; ferr0 = ferr_cnt;
    cs_low();
    spi_bits(8'h96, 4, mb);
    rst = 1'b1;
    clks(2);
    rst = 1'b0;
    chk("t5_rst_rx_data", rx_data, 8'h00);
    chk("t5_rst_active", frame_active, 1'b0);
    spi_bits(8'h69, 4, mb);
    cs_high();
    chk("t5_no_rxv", rxv_cnt - rxv0, 0);
    chk("t5_no_error", ferr_cnt - ferr0, 0);
    chk("t5_inactive", frame_active, 1'b0);
    rxv0 = rxv_cnt;
    cs_low();
    spi_bits(8'h5A, 8, mb);
    cs_high();
    chk("t5_rx_data", rx_data, 8'h5A);
    chk("t5_rxv_count", rxv_cnt - rxv0, 1);

    // 6: SCLK activity with CS high is ignored
    rst = 1'b1;
    clks(2);
    rst = 1'b0;
    clks(4);
    rxv0 = rxv_cnt; ferr0 = ferr_cnt;
    tx_data = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      spi_mosi = i[0];
      spi_sclk = ~spi_sclk;
      clks(8);
      chk("t6_miso", spi_miso, 1'b0);
    end
    clks(4);
    chk("t6_no_rxv", rxv_cnt - rxv0, 0);
    chk("t6_no_error", ferr_cnt - ferr0, 0);
    chk("t6_byte_count", byte_count, 8'd0);
    chk("t6_inactive", frame_active, 1'b0);

    chk("never_both_pulses", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
